// File: rtl/pipelined_data_path.sv
// EX/MEM/WB datapath with internal regfile and data memory; writeback 2 cycles after accept, branch pulse 1 cycle after.
// in_ready drops for one cycle on a load-use hazard (a bubble enters MEM); otherwise one instruction per cycle.
module pipelined_data_path #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int DM_AW = 5,
  parameter bit ZERO_REG = 1'b1,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   imm,
  input  logic              use_imm,
  output logic              br_eq,
  output logic              br_ne,
  output logic              br_lt,
  output logic              br_ge,
  output logic              br_taken,
  output logic [DM_AW-1:0]  dm_addr,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [31:0]       retire_cnt
);

  localparam int SHW   = $clog2(XLEN);
  localparam int DEPTH = 2 ** DM_AW;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_LUI  = 5'd10;
  localparam logic [4:0] OP_LW   = 5'd11;
  localparam logic [4:0] OP_SW   = 5'd12;
  localparam logic [4:0] OP_BEQ  = 5'd13;
  localparam logic [4:0] OP_BNE  = 5'd14;
  localparam logic [4:0] OP_BLT  = 5'd15;
  localparam logic [4:0] OP_BGE  = 5'd16;

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic              ld;
    logic              st;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   res;
    logic [XLEN-1:0]   st_dat;
    logic [DM_AW-1:0]  addr;
    logic [3:0]        br;   // {eq, ne, lt, ge}
  } mem_t;

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   dat;
  } wb_t;

  mem_t mem_q, mem_d;
  wb_t  wb_q;

  logic [XLEN-1:0] rf   [NREG];
  logic [XLEN-1:0] dmem [DEPTH];

  logic            mem_fwd_ok, wb_fwd_ok;
  logic            ex_reads_b, load_use, accept;
  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res;
  logic [SHW-1:0]  shamt;

  // Loads cannot forward from MEM: their data only exists once captured into WB.
  assign mem_fwd_ok = mem_q.vld & mem_q.wr & ~mem_q.ld;
  assign wb_fwd_ok  = wb_q.vld & wb_q.wr;

  always_comb begin
    op_a = rf[rs1];
    if (wb_fwd_ok && wb_q.rd == rs1) op_a = wb_q.dat;
    if (mem_fwd_ok && mem_q.rd == rs1) op_a = mem_q.res;
    if (ZERO_REG && rs1 == '0) op_a = '0;
  end

  always_comb begin
    op_b = rf[rs2];
    if (wb_fwd_ok && wb_q.rd == rs2) op_b = wb_q.dat;
    if (mem_fwd_ok && mem_q.rd == rs2) op_b = mem_q.res;
    if (ZERO_REG && rs2 == '0) op_b = '0;
  end

  assign ex_reads_b = ~use_imm | (op == OP_SW) | ((op >= OP_BEQ) && (op <= OP_BGE));
  assign load_use   = in_valid & mem_q.vld & mem_q.ld & (mem_q.rd != '0) &
                      ((rs1 == mem_q.rd) | (ex_reads_b & (rs2 == mem_q.rd)));
  assign in_ready   = ~rst & ~load_use;
  assign accept     = in_valid & in_ready;

  assign alu_b = use_imm ? imm : op_b;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + alu_b;
      OP_SUB:  alu_res = op_a - alu_b;
      OP_AND:  alu_res = op_a & alu_b;
      OP_OR:   alu_res = op_a | alu_b;
      OP_XOR:  alu_res = op_a ^ alu_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < alu_b)};
      OP_LUI:  alu_res = imm;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    mem_d        = '0;
    mem_d.vld    = accept;
    mem_d.wr     = accept & (op <= OP_LW) & ~(ZERO_REG && rd == '0);
    mem_d.ld     = accept & (op == OP_LW);
    mem_d.st     = accept & (op == OP_SW);
    mem_d.rd     = rd;
    mem_d.res    = alu_res;
    mem_d.st_dat = op_b;
    mem_d.addr   = DM_AW'(op_a + imm);
    if (accept) begin
      mem_d.br = {(op == OP_BEQ) && (op_a == op_b),
                  (op == OP_BNE) && (op_a != op_b),
                  (op == OP_BLT) && ($signed(op_a) <  $signed(op_b)),
                  (op == OP_BGE) && ($signed(op_a) >= $signed(op_b))};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '0;
      wb_q       <= '0;
      retire_cnt <= '0;
    end else begin
      mem_q     <= mem_d;
      wb_q.vld  <= mem_q.vld;
      wb_q.wr   <= mem_q.wr;
      wb_q.rd   <= mem_q.rd;
      wb_q.dat  <= mem_q.ld ? dmem[mem_q.addr] : mem_q.res;
      if (wb_q.vld) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (mem_q.vld && mem_q.st) begin
      dmem[mem_q.addr] <= mem_q.st_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_q.vld && wb_q.wr) begin
      rf[wb_q.rd] <= wb_q.dat;
    end
  end

  assign br_eq    = mem_q.br[3];
  assign br_ne    = mem_q.br[2];
  assign br_lt    = mem_q.br[1];
  assign br_ge    = mem_q.br[0];
  assign br_taken = |mem_q.br;
  assign dm_addr  = mem_q.addr;
  assign wb_valid = wb_q.vld & wb_q.wr;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.dat;

endmodule

// File: tb/tb_pipelined_data_path.sv
// Directed + random bench for pipelined_data_path; an architectural (one-instruction-at-a-time) model
// predicts results, scheduled onto the MEM (+1) and WB (+2) cycles after each accept.
module tb_pipelined_data_path;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm = '0;
  logic        use_imm = 1'b0;
  logic        br_eq, br_ne, br_lt, br_ge, br_taken;
  logic [4:0]  dm_addr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  pipelined_data_path dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
    .br_eq(br_eq), .br_ne(br_ne), .br_lt(br_lt), .br_ge(br_ge), .br_taken(br_taken),
    .dm_addr(dm_addr), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  // architectural state
  logic [31:0] R [32];
  logic [31:0] M [32];

  // expectations per cycle slot (cycle mod 4)
  logic        e_wbv  [4];
  logic [4:0]  e_wbrd [4];
  logic [31:0] e_wbd  [4];
  logic        e_inwb [4];
  logic [3:0]  e_br   [4];
  logic        e_dmv  [4];
  logic [4:0]  e_dm   [4];
  int          e_ret;
  logic        prev_ld;
  logic [4:0]  prev_rd;
  logic        acc;
  int          stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      R[i] = '0;
      M[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      e_wbv[i] = 0; e_wbrd[i] = '0; e_wbd[i] = '0; e_inwb[i] = 0;
      e_br[i] = '0; e_dmv[i] = 0; e_dm[i] = '0;
    end
    e_ret = 0;
    prev_ld = 0;
    prev_rd = '0;
  endtask

  // One clock cycle: check outputs against schedule, then execute any accepted instruction in the model.
  task automatic step();
    int s, s1, s2;
    logic reads2, exp_rdy;
    logic [31:0] a, b, bb, res, addr;
    logic [4:0] ai;
    logic wv;
    @(negedge clk);
    s = cyc % 4; s1 = (cyc + 1) % 4; s2 = (cyc + 2) % 4;
    chk("wb_valid", 32'(wb_valid), 32'(e_wbv[s]));
    if (e_wbv[s]) begin
      chk("wb_rd", 32'(wb_rd), 32'(e_wbrd[s]));
      chk("wb_data", wb_data, e_wbd[s]);
    end
    chk("br_flags", 32'({br_eq, br_ne, br_lt, br_ge}), 32'(e_br[s]));
    chk("br_taken", 32'(br_taken), 32'(|e_br[s]));
    if (e_dmv[s]) chk("dm_addr", 32'(dm_addr), 32'(e_dm[s]));
    chk("retire_cnt", retire_cnt, 32'(e_ret));
    reads2 = !use_imm || op == 5'd12 || (op >= 5'd13 && op <= 5'd16);
    if (in_valid) begin
      exp_rdy = !(prev_ld && prev_rd != 0 && (rs1 == prev_rd || (reads2 && rs2 == prev_rd)));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    end
    acc = in_valid && in_ready;
    if (e_inwb[s]) e_ret++;
    e_wbv[s] = 0; e_inwb[s] = 0; e_br[s] = '0; e_dmv[s] = 0;
    prev_ld = 0;
    if (acc) begin
      a = R[rs1]; b = R[rs2];
      bb = use_imm ? imm : b;
      addr = a + imm;
      ai = addr[4:0];
      res = '0;
      case (op)
        5'd0:  res = a + bb;
        5'd1:  res = a - bb;
        5'd2:  res = a & bb;
        5'd3:  res = a | bb;
        5'd4:  res = a ^ bb;
        5'd5:  res = a << bb[4:0];
        5'd6:  res = a >> bb[4:0];
        5'd7:  res = $signed(a) >>> bb[4:0];
        5'd8:  res = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
        5'd9:  res = (a < bb) ? 32'd1 : 32'd0;
        5'd10: res = imm;
        5'd11: res = M[ai];
        default: res = '0;
      endcase
      if (op == 5'd12) M[ai] = b;
      wv = (op <= 5'd11) && (rd != 0);
      if (wv) R[rd] = res;
      e_br[s1] = {op == 5'd13 && a == b, op == 5'd14 && a != b,
                  op == 5'd15 && $signed(a) < $signed(b), op == 5'd16 && $signed(a) >= $signed(b)};
      e_dmv[s1] = (op == 5'd11 || op == 5'd12);
      e_dm[s1] = ai;
      e_wbv[s2] = wv; e_wbrd[s2] = rd; e_wbd[s2] = res; e_inwb[s2] = 1;
      prev_ld = (op == 5'd11);
      prev_rd = rd;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic issue(input logic [4:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input logic ui);
    int n;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; use_imm = ui;
    in_valid = 1;
    stalls = 0;
    n = 0;
    do begin
      step();
      if (!acc) stalls++;
      n++;
    end while (!acc && n < 6);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    clear_model();
    @(negedge clk);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_br_taken", 32'(br_taken), 32'd0);
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    clear_model();
    do_reset();

    // back-to-back dependent adds
    issue(5'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    issue(5'd0, 5'd2, 5'd1, 5'd1, 32'd0, 1'b0);
    chk("no_stall_add", 32'(stalls), 32'd0);
    idle(3);
    chk("retire_two", retire_cnt, 32'd2);

    // store, load, load-use
    issue(5'd12, 5'd0, 5'd0, 5'd2, 32'd3, 1'b1);
    issue(5'd11, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1);
    issue(5'd0, 5'd4, 5'd3, 5'd3, 32'd0, 1'b0);
    chk("load_use_stalls", 32'(stalls), 32'd1);
    idle(3);

    // branches
    issue(5'd13, 5'd0, 5'd1, 5'd1, 32'd0, 1'b0);
    issue(5'd1, 5'd2, 5'd0, 5'd0, 32'd1, 1'b1);
    issue(5'd15, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0);
    idle(3);

    // zero register
    issue(5'd0, 5'd0, 5'd0, 5'd0, 32'd7, 1'b1);
    issue(5'd0, 5'd5, 5'd0, 5'd0, 32'd0, 1'b0);
    idle(3);

    // arithmetic corners
    issue(5'd10, 5'd6, 5'd0, 5'd0, 32'h8000_0000, 1'b1);
    issue(5'd7, 5'd7, 5'd6, 5'd0, 32'd4, 1'b1);
    issue(5'd0, 5'd8, 5'd0, 5'd0, 32'd1, 1'b1);
    issue(5'd10, 5'd9, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    issue(5'd9, 5'd10, 5'd8, 5'd9, 32'd0, 1'b0);
    issue(5'd0, 5'd11, 5'd9, 5'd0, 32'd1, 1'b1);
    idle(3);

    // reset with instructions in flight
    issue(5'd12, 5'd0, 5'd0, 5'd2, 32'd7, 1'b1);
    issue(5'd0, 5'd12, 5'd1, 5'd1, 32'd0, 1'b0);
    issue(5'd13, 5'd0, 5'd1, 5'd1, 32'd0, 1'b0);
    do_reset();
    idle(3);
    issue(5'd11, 5'd13, 5'd0, 5'd0, 32'd7, 1'b1);
    idle(3);

    // randomized traffic over a small register window to provoke hazards
    for (int k = 0; k < 400; k++) begin
      logic [4:0] ro;
      logic [31:0] ri;
      ro = 5'($urandom_range(0, 20));
      ri = (ro == 5'd11 || ro == 5'd12) ? $urandom_range(0, 40) : $urandom;
      issue(ro, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ri, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
      if (k == 200) do_reset();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pipelined_data_path.md
# pipelined_data_path

Parametrised three-stage (EX/MEM/WB) successor to the single-cycle datapath. It owns an internal register file and an internal word-addressed data memory, and accepts one decoded instruction per cycle over a valid/ready handshake. It forwards results between stages and stalls one cycle on load-use hazards. Registered branch-condition pulses go to the fetch unit, and a writeback observation port plus a retire counter support verification.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8, power of two)
- NREG, 32, register count; REG_AW = clog2(NREG)
- DM_AW, 5, data-memory address bits; depth 2^DM_AW words of XLEN
- ZERO_REG, 1, register 0 reads as 0 and ignores writes when 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  block can accept (0 only during load-use stall or rst)
- op  in  5  opcode (see Operation)
- rs1, rs2, rd  in  REG_AW  source/destination register numbers
- imm  in  XLEN  immediate (pre-extended by decoder)
- use_imm  in  1  ALU operand B = imm instead of rs2 (ops 0-9)
- br_eq, br_ne, br_lt, br_ge  out  1  one-cycle condition-true pulses for BEQ/BNE/BLT/BGE
- br_taken  out  1  OR of the four flags
- dm_addr  out  DM_AW  word address of the MEM-stage access
- wb_valid  out  1  register write in progress this cycle
- wb_rd  out  REG_AW  register written
- wb_data  out  XLEN  value written
- retire_cnt  out  32  instructions retired, wraps at 2^32

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 LUI (rd←imm), 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 BLT (signed), 16 BGE (signed), 17-31 NOP.
- Arithmetic is modulo 2^XLEN. The shift amount is B[clog2(XLEN)-1:0]. SLT/SLTU write 1 or 0.
- LW/SW: address = rs1+imm, truncated to the low DM_AW bits (word index, wraps modulo depth). SW data = forwarded rs2.
- Writeback ops are 0-11 only. SW, branches and NOPs retire without a register write. With ZERO_REG=1, writes to rd=0 are dropped and wb_valid stays 0.
- EX (accept cycle): operands are read combinationally. Per operand, the source priority is: MEM-stage result (non-load only), then WB-stage value (including load data), then register file. Never forward from register 0 when ZERO_REG=1. The ALU/branch compare result is captured into the MEM register.
- MEM: SW writes memory at the end of MEM. LW issues a synchronous read and the data is captured into the WB register.
- WB: register-file write at the end of WB. wb_* mirror this write.
- Load-use stall: if the MEM stage holds an LW with rd≠0 and the input instruction reads that rd (rs1 always; rs2 if use_imm=0 or op∈{SW, branches}), in_ready=0 for that cycle. A bubble enters MEM, and the instruction is accepted the next cycle with WB forwarding.
- Branch flags are registered and pulse in the cycle after acceptance. The block does not flush; squashing is the fetch unit's job.
- retire_cnt increments by 1 in every cycle in which the WB stage holds a valid instruction, of any op.

## Timing
- Reset (sync): all stage valids 0; register file and data memory cleared to 0. br_*, br_taken, wb_valid, wb_rd, wb_data, dm_addr and retire_cnt are 0. in_ready is 0 while rst=1 and 1 in the first cycle after.
- Accept at edge t (in_valid & in_ready). MEM occupies cycle t+1: dm_addr is valid and branch flags pulse. WB occupies cycle t+2: wb_* are valid, the register file is written at the end of t+2, and retire_cnt updates at that edge.
- Throughput: one instruction per cycle with no hazard; one bubble per load-use.
- in_valid=0 inserts a bubble. The op/rs/imm inputs are ignored when the instruction is not accepted.
- SW then LW to the same word on consecutive accepts: the LW returns the new data.
- A WB write and an EX read of the same register in the same cycle: the forwarded WB value is used.
- rst asserted mid-pipeline: in-flight instructions are discarded with no writes or pulses, and memory and registers are cleared.

## Test plan
- Reset, then ADD x1 = x0+imm 5 (use_imm), ADD x2 = x1+x1 back-to-back → wb_data 5 then 10 on consecutive cycles, no stall, retire_cnt=2.
- SW x2 → imm 3; then LW x3 ← imm 3; then ADD x4 = x3+x3 → exactly one in_ready=0 cycle before the ADD is accepted; wb_data 10, then 20; dm_addr=3.
- BEQ x1,x1, then BLT x1(5),x2(-1 via SUB) → br_eq=br_taken=1 for one cycle; second branch gives all flags 0.
- Write to x0 with ZERO_REG=1, then ADD x5 = x0+x0 → wb_valid=0 for the first; x5 = 0.
- SRA of 0x8000_0000 by 4 = 0xF800_0000; SLTU 1 vs 0xFFFF_FFFF = 1; ADD 0xFFFF_FFFF+1 = 0.
- rst pulsed while three instructions are in flight → no wb_valid and no br pulses afterward; retire_cnt=0; LW of a previously stored word returns 0.
